// File: rtl/sdm_cic_decimator.sv
// Third-order CIC (sinc^3) decimator for a 1-bit sigma-delta bitstream, ratio R = 2^DEC_LOG2.
// Define CIC_TRUNC16_EN for a fixed 16-bit output (MSB-aligned truncation or sign extension).
module sdm_cic_decimator #(
  parameter int DEC_LOG2 = 4,
  localparam int ACC_W = 3 * DEC_LOG2 + 2,
`ifdef CIC_TRUNC16_EN
  localparam int OUT_W = 16
`else
  localparam int OUT_W = 3 * DEC_LOG2 + 2
`endif
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             BIT_IN,
  input  logic             BIT_VALID,
  output logic [OUT_W-1:0] DATAWORD_OUT,
  output logic             DATA_VALID
);

  logic [ACC_W-1:0]    x;
  logic [ACC_W-1:0]    i1, i2, i3;
  logic [ACC_W-1:0]    i1_n, i2_n, i3_n;
  logic [ACC_W-1:0]    d1, d2, d3;
  logic [ACC_W-1:0]    c1, c2, c3;
  logic [OUT_W-1:0]    c3_out;
  logic [DEC_LOG2-1:0] cnt;
  logic                dec_stb;

  // Bit 1 means the quantizer went negative, so it maps to -1 (all ones).
  assign x = BIT_IN ? '1 : ACC_W'(1);

  // Modulo-2^ACC_W wrap in every stage is intended; the comb undoes it exactly.
  always_comb begin
    i1_n = i1 + x;
    i2_n = i2 + i1_n;
    i3_n = i3 + i2_n;
    c1   = i3 - d1;
    c2   = c1 - d2;
    c3   = c2 - d3;
  end

`ifdef CIC_TRUNC16_EN
  if (ACC_W > 16) begin : g_trunc
    assign c3_out = c3[ACC_W-1 -: 16];
  end else begin : g_sext
    assign c3_out = 16'($signed(c3));
  end
`else
  assign c3_out = c3;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      i1           <= '0;
      i2           <= '0;
      i3           <= '0;
      d1           <= '0;
      d2           <= '0;
      d3           <= '0;
      cnt          <= '0;
      dec_stb      <= 1'b0;
      DATAWORD_OUT <= '0;
      DATA_VALID   <= 1'b0;
    end else begin
      dec_stb    <= 1'b0;
      DATA_VALID <= 1'b0;
      if (BIT_VALID) begin
        i1  <= i1_n;
        i2  <= i2_n;
        i3  <= i3_n;
        cnt <= cnt + DEC_LOG2'(1);
        if (&cnt) dec_stb <= 1'b1;
      end
      // Comb samples the pre-update I3, which already holds the window's last bit.
      if (dec_stb) begin
        d1           <= i3;
        d2           <= c1;
        d3           <= c2;
        DATAWORD_OUT <= c3_out;
        DATA_VALID   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdm_cic_decimator.sv
// Bench for sdm_cic_decimator: directed table, reset corner sequences and random bitstreams vs a sinc^3 model.
module tb_sdm_cic_decimator;
  localparam int DEC_LOG2 = 4;
  localparam int R        = 1 << DEC_LOG2;
  localparam int ACC_W    = 3 * DEC_LOG2 + 2;
`ifdef CIC_TRUNC16_EN
  localparam int W = 16;
`else
  localparam int W = ACC_W;
`endif

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic         BIT_IN;
  logic         BIT_VALID;
  logic [W-1:0] DATAWORD_OUT;
  logic         DATA_VALID;

  // clock / reset block
  always #5 CLOCK = ~CLOCK;

  initial begin
    RESET     = 1'b1;
    BIT_IN    = 1'b0;
    BIT_VALID = 1'b0;
  end

  sdm_cic_decimator #(.DEC_LOG2(DEC_LOG2)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .BIT_IN      (BIT_IN),
    .BIT_VALID   (BIT_VALID),
    .DATAWORD_OUT(DATAWORD_OUT),
    .DATA_VALID  (DATA_VALID)
  );

  // scoreboard state
  int           tests = 0;
  int           fails = 0;
  int           cyc   = 0;
  int           xs[$];
  longint       i3_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_word = '0;
  logic         exp_valid = 1'b0;
  int           cap_val[$];
  int           cap_cyc[$];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic longint i3_at(input int idx);
    return (idx < 0) ? 64'sd0 : i3_q[idx];
  endfunction

  function automatic logic [W-1:0] to_out(input longint y);
    longint t;
`ifdef CIC_TRUNC16_EN
    t = (ACC_W > 16) ? (y >>> (ACC_W - 16)) : y;
`else
    t = y;
`endif
    return W'(t);
  endfunction

  // Triple running sum at sample n is sum_j x_j * C(n-j+2, 2); the three combs form a third difference.
  task automatic window_end();
    longint acc = 0;
    longint y;
    int     n = xs.size();
    int     k;
    for (int j = 0; j < n; j++) begin
      longint m = n - j;
      acc += longint'(xs[j]) * m * (m + 1) / 2;
    end
    i3_q.push_back(acc);
    k = i3_q.size() - 1;
    y = i3_at(k) - 3 * i3_at(k - 1) + 3 * i3_at(k - 2) - i3_at(k - 3);
    exp_q.push_back(to_out(y));
  endtask

  // driver: one clock with the given inputs, then model update and output checks
  task automatic step(input logic b, input logic v, input logic r);
    BIT_IN    = b;
    BIT_VALID = v;
    RESET     = r;
    @(posedge CLOCK);
    #1;
    cyc++;
    if (r) begin
      xs.delete();
      i3_q.delete();
      exp_q.delete();
      exp_valid = 1'b0;
      last_word = '0;
    end else begin
      exp_valid = (exp_q.size() > 0);
      if (exp_valid) last_word = exp_q.pop_front();
      if (v) begin
        xs.push_back(b ? -1 : 1);
        if (xs.size() % R == 0) window_end();
      end
    end
    check("data_valid", longint'(DATA_VALID), longint'(exp_valid));
    check("dataword_out", longint'(DATAWORD_OUT), longint'(last_word));
    if (DATA_VALID) begin
      cap_val.push_back(int'($signed(DATAWORD_OUT)));
      cap_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    cap_val.delete();
    cap_cyc.delete();
  endtask

  typedef struct {
    int mode;   // 0: all 0, 1: all 1, 2: alternating, 3: zeros with valid every other cycle
    int ncyc;
    int e0, e1, e2, e3;
    int gap;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{0, 170, 816, 3536, 4096, 4096, 16};
    vecs[1] = '{1, 170, -816, -3536, -4096, -4096, 16};
    vecs[2] = '{2, 170, 72, 56, 0, 0, 16};
    vecs[3] = '{3, 340, 816, 3536, 4096, 4096, 32};

    for (int t = 0; t < 4; t++) begin
      do_reset();
      for (int c = 0; c < vecs[t].ncyc; c++) begin
        case (vecs[t].mode)
          0:       step(1'b0, 1'b1, 1'b0);
          1:       step(1'b1, 1'b1, 1'b0);
          2:       step(1'(c % 2), 1'b1, 1'b0);
          default: step(1'b0, 1'((c % 2) == 0), 1'b0);
        endcase
      end
      check($sformatf("vec%0d_count", t), cap_val.size(), 10);
      if (cap_val.size() >= 4) begin
        check($sformatf("vec%0d_out0", t), cap_val[0], vecs[t].e0);
        check($sformatf("vec%0d_out1", t), cap_val[1], vecs[t].e1);
        check($sformatf("vec%0d_out2", t), cap_val[2], vecs[t].e2);
        check($sformatf("vec%0d_out3", t), cap_val[3], vecs[t].e3);
        check($sformatf("vec%0d_steady", t), cap_val[cap_val.size() - 1], vecs[t].e3);
        check($sformatf("vec%0d_gap", t), cap_cyc[1] - cap_cyc[0], vecs[t].gap);
      end
    end

    // Reset after 7 valid bits: partial window is dropped and the next window restarts at 816.
    do_reset();
    for (int c = 0; c < 7; c++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("midwin_rst_valid", longint'(DATA_VALID), 0);
    check("midwin_rst_word", longint'(DATAWORD_OUT), 0);
    cap_val.delete();
    for (int c = 0; c < 18; c++) step(1'b0, 1'b1, 1'b0);
    check("midwin_count", cap_val.size(), 1);
    if (cap_val.size() > 0) check("midwin_first", cap_val[0], 816);

    // Reset on the comb edge: the pending strobe must be cancelled.
    do_reset();
    for (int c = 0; c < R; c++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("strobe_rst_valid", longint'(DATA_VALID), 0);
    cap_val.delete();
    for (int c = 0; c < R + 4; c++) step(1'b0, 1'b1, 1'b0);
    check("strobe_rst_count", cap_val.size(), 1);
    if (cap_val.size() > 0) check("strobe_rst_first", cap_val[0], 816);

    // Random bitstream, random gaps in BIT_VALID, occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 399) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
